// File: rtl/serial_frame_pkg.sv
// Shared types for the serial framer: FSM state encoding and the default
// idle line level.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } ser_state_t;

  localparam logic IDLE_LVL_DEFAULT = 1'b1;

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: accepts a WIDTH-bit word on a valid/ready
// handshake, emits it one bit per clock on q_out, then spends one guard
// cycle in S_GAP with frame_done high before accepting again.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN appends an even-parity
// bit after the data bits (S_PARITY); without it S_PARITY is unreachable.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_LVL  = IDLE_LVL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             q_out,
  output logic             q_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             head;

  // The accept only steers internal registers; outputs decode from state.
  assign accept = (state == S_IDLE) && d_valid;
  assign head   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic par;

  // Even-parity bit captured alongside the word so later d_in changes are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^d_in;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register and bit counter: load on accept, advance while shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= d_in;
      cnt   <= '0;
    end else if (state == S_SHIFT) begin
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      if (cnt != CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Next-state and output decode; defaults are the idle/reset values.
  always_comb begin
    state_nxt  = S_IDLE;
    d_ready    = 1'b1;
    q_out      = IDLE_LVL;
    q_valid    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = d_valid ? S_SHIFT : S_IDLE;
      end
      S_SHIFT: begin
        d_ready = 1'b0;
        busy    = 1'b1;
        q_out   = head;
        q_valid = 1'b1;
        if (cnt == CNT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_GAP;
`endif
        end else begin
          state_nxt = S_SHIFT;
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        d_ready   = 1'b0;
        busy      = 1'b1;
        q_out     = par;
        q_valid   = 1'b1;
        state_nxt = S_GAP;
      end
`endif
      S_GAP: begin
        d_ready    = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an MSB-first instance (idle level 1) and an
// LSB-first instance (idle level 0) share one stimulus stream. A queue-based
// frame model predicts every cycle's outputs; directed frames pin the model
// against hand-computed literal bit patterns.
module tb_serial_frame_tx;

  localparam int W = 8;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         d_valid = 1'b0;
  logic [W-1:0] d_in = '0;

  logic d_ready_m, q_out_m, q_valid_m, busy_m, frame_done_m;
  logic d_ready_l, q_out_l, q_valid_l, busy_l, frame_done_l;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) dut_m (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid),
    .d_ready(d_ready_m), .q_out(q_out_m), .q_valid(q_valid_m),
    .busy(busy_m), .frame_done(frame_done_m)
  );

  serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid),
    .d_ready(d_ready_l), .q_out(q_out_l), .q_valid(q_valid_l),
    .busy(busy_l), .frame_done(frame_done_l)
  );

  // One entry per upcoming non-idle cycle; an empty queue means idle.
  typedef struct {
    bit v;
    bit bm;
    bit bl;
    bit fd;
  } ent_t;

  ent_t mq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  logic sm [0:8191];
  logic sl [0:8191];
  logic sv [0:8191];
  logic sf [0:8191];
  logic sr [0:8191];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.v = 1'b1; e.bm = w[W-1-i]; e.bl = w[i]; e.fd = 1'b0;
      mq.push_back(e);
    end
    if (P == 1) begin
      e.v = 1'b1; e.bm = ^w; e.bl = ^w; e.fd = 1'b0;
      mq.push_back(e);
    end
    e.v = 1'b0; e.bm = 1'b0; e.bl = 1'b0; e.fd = 1'b1;
    mq.push_back(e);
  endtask

  // Advance one clock: update the model at the edge, then compare every output.
  task automatic tick();
    ent_t e;
    bit   idle;
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (d_valid) push_frame(d_in);
    end else begin
      void'(mq.pop_front());
    end
    @(negedge clk);
    cyc++;
    idle = (mq.size() == 0);
    if (idle) begin
      e.v = 1'b0; e.bm = 1'b0; e.bl = 1'b0; e.fd = 1'b0;
    end else begin
      e = mq[0];
    end
    chk("q_valid_m", {7'd0, q_valid_m}, {7'd0, e.v});
    chk("q_valid_l", {7'd0, q_valid_l}, {7'd0, e.v});
    chk("q_out_m", {7'd0, q_out_m}, {7'd0, e.v ? e.bm : 1'b1});
    chk("q_out_l", {7'd0, q_out_l}, {7'd0, e.v ? e.bl : 1'b0});
    chk("busy_m", {7'd0, busy_m}, {7'd0, !idle});
    chk("d_ready_m", {7'd0, d_ready_m}, {7'd0, idle});
    chk("d_ready_l", {7'd0, d_ready_l}, {7'd0, idle});
    chk("frame_done_m", {7'd0, frame_done_m}, {7'd0, e.fd});
    chk("frame_done_l", {7'd0, frame_done_l}, {7'd0, e.fd});
    sm[cyc] = q_out_m;
    sl[cyc] = q_out_l;
    sv[cyc] = q_valid_m;
    sf[cyc] = frame_done_m;
    sr[cyc] = d_ready_m;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (d_ready_m !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("ready_timeout", {7'd0, d_ready_m}, 8'd1);
  endtask

  // Accept w on the next edge; returns with cyc = E+1, E returned in ea.
  task automatic send(input logic [W-1:0] w, output int ea);
    wait_ready();
    d_in = w;
    d_valid = 1'b1;
    tick();
    ea = cyc - 1;
    d_valid = 1'b0;
    d_in = W'($urandom);
  endtask

  // Eight serial bits starting at cycle base, first bit in the byte MSB.
  function automatic logic [7:0] strm(input int base, input bit lsb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = lsb ? sl[base+i] : sm[base+i];
    return r;
  endfunction

  initial begin
    int e;
    int cntv;
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_q_out_m", {7'd0, q_out_m}, 8'd1);
    chk("rst_q_out_l", {7'd0, q_out_l}, 8'd0);
    chk("rst_q_valid", {7'd0, q_valid_m}, 8'd0);
    chk("rst_busy", {7'd0, busy_m}, 8'd0);
    chk("rst_ready", {7'd0, d_ready_m}, 8'd1);
    chk("rst_done", {7'd0, frame_done_m}, 8'd0);
    reset = 1'b0;
    tick();

    // MSB-first 8'hA5
    send(8'hA5, e);
    repeat (W + 4) tick();
    chk("a5_msb_stream", strm(e + 1, 1'b0), 8'hA5);
    chk("a5_lsb_stream", strm(e + 1, 1'b1), 8'hA5);
    cntv = 0;
    for (int k = 1; k <= W; k++) cntv += int'(sv[e+k]);
    chk("a5_valid_count", 8'(cntv), 8'd8);
    chk("a5_done_before", {7'd0, sf[e+8+P]}, 8'd0);
    chk("a5_done", {7'd0, sf[e+9+P]}, 8'd1);
    chk("a5_gap_q_out", {7'd0, sm[e+9+P]}, 8'd1);
    chk("a5_ready_again", {7'd0, sr[e+10+P]}, 8'd1);

    // 8'h07: three trailing ones, parity bit 1 when enabled
    send(8'h07, e);
    repeat (W + 4) tick();
    chk("07_msb_stream", strm(e + 1, 1'b0), 8'h07);
    chk("07_lsb_stream", strm(e + 1, 1'b1), 8'hE0);
    if (P == 1) begin
      chk("07_parity_bit", {7'd0, sm[e+9]}, 8'd1);
      chk("07_parity_valid", {7'd0, sv[e+9]}, 8'd1);
      chk("07_done", {7'd0, sf[e+10]}, 8'd1);
    end else begin
      chk("07_done", {7'd0, sf[e+9]}, 8'd1);
    end

    // 8'h01: LSB-first sends the 1 first
    send(8'h01, e);
    repeat (W + 4) tick();
    chk("01_lsb_stream", strm(e + 1, 1'b1), 8'h80);
    chk("01_msb_stream", strm(e + 1, 1'b0), 8'h01);

    // Back-to-back with d_valid held high; d_in changes right after accept
    wait_ready();
    d_in = 8'hFF;
    d_valid = 1'b1;
    tick();
    e = cyc - 1;
    d_in = 8'h00;
    repeat (2 * W + 6) tick();
    d_valid = 1'b0;
    repeat (W + 5) tick();
    chk("b2b_first", strm(e + 1, 1'b0), 8'hFF);
    chk("b2b_gap", {7'd0, sv[e+9+P]}, 8'd0);
    chk("b2b_accept_cycle", {7'd0, sv[e+10+P]}, 8'd0);
    chk("b2b_accept_ready", {7'd0, sr[e+10+P]}, 8'd1);
    chk("b2b_second", strm(e + 11 + P, 1'b0), 8'h00);
    cntv = 0;
    for (int k = 1; k <= W + P; k++) cntv += int'(sv[e+k]);
    chk("b2b_first_valid", 8'(cntv), 8'(W + P));
    cntv = 0;
    for (int k = 11 + P; k <= 10 + W + 2 * P; k++) cntv += int'(sv[e+k]);
    chk("b2b_second_valid", 8'(cntv), 8'(W + P));

    // Reset during the 4th data bit
    send(8'h3C, e);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_q_out", {7'd0, q_out_m}, 8'd1);
    chk("mid_rst_q_valid", {7'd0, q_valid_m}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy_m}, 8'd0);
    chk("mid_rst_ready", {7'd0, d_ready_m}, 8'd1);
    repeat (W + 4) tick();
    cntv = 0;
    for (int k = 1; k <= W + 9; k++) cntv += int'(sf[e+k]);
    chk("mid_rst_no_done", 8'(cntv), 8'd0);
    send(8'h96, e);
    repeat (W + 4) tick();
    chk("post_rst_stream", strm(e + 1, 1'b0), 8'h96);
    chk("post_rst_done", {7'd0, sf[e+9+P]}, 8'd1);

    // d_valid pulsed while busy is ignored
    send(8'hC3, e);
    repeat (2) tick();
    d_in = 8'h5A;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    repeat (W + 4) tick();
    chk("busy_pulse_stream", strm(e + 1, 1'b0), 8'hC3);
    chk("busy_pulse_idle", {7'd0, busy_m}, 8'd0);

    // Reset and d_valid on the same edge: reset wins
    wait_ready();
    reset = 1'b1;
    d_valid = 1'b1;
    tick();
    reset = 1'b0;
    d_valid = 1'b0;
    chk("rst_vs_valid_busy", {7'd0, busy_m}, 8'd0);
    chk("rst_vs_valid_qv", {7'd0, q_valid_m}, 8'd0);

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      d_valid = ($urandom_range(0, 2) != 0);
      d_in = W'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    d_valid = 1'b0;
    repeat (W + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
